inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch -- instruction fetch stage with a 2-entry {pc, inst} queue.
//
// Fetches sequential words from an instruction ROM, buffers up to two
// fetched instructions for decode, and restarts at a new PC on redirect.
//
// Ports
//   clk            : clock, all state on rising edge
//   rst            : asynchronous active-low reset
//   rom_cs         : ROM request strobe (high only while fetching)
//   rom_addr       : ROM word address = {2'b00, pc[31:2]}
//   rom_dout       : ROM read data, valid when rom_cs & ~rom_stall
//   rom_stall      : ROM busy; low for one cycle per completed access
//   redirect       : branch/jump redirect request
//   redirect_pc    : redirect byte target (low two bits ignored)
//   if_valid       : queue head holds a valid instruction
//   if_inst        : queue-head instruction word (0 when empty)
//   if_pc          : byte PC of if_inst (0 when empty)
//   id_ready       : decode accepts the head when if_valid & id_ready
//   perf_stall_cnt : ROM wait-cycle counter
//
// Configuration
//   IF_PERF_CNT_EN : when defined, perf_stall_cnt counts cycles with
//                    rom_cs & rom_stall; otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_cs,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_dout,
    input  logic        rom_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    output logic [31:0] perf_stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_REDIR = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [1:0]  r_cnt;
    logic [31:0] r_q_pc   [2];
    logic [31:0] r_q_inst [2];

    logic        w_flush;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_cnt_nxt;
    logic [1:0]  w_wr_slot;
    logic        w_unused;

    // A redirect only matters once the fetch engine is running.
    assign w_flush = redirect && (r_state != S_IDLE);
    // Redirect wins over both queue operations; same-cycle ROM data is dropped.
    assign w_push  = (r_state == S_FETCH) && !rom_stall && !w_flush;
    assign w_pop   = (r_cnt != 2'd0) && id_ready && !w_flush;

    assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    // Slot to write on push: after a same-cycle pop the entries shift down one.
    assign w_wr_slot = r_cnt - {1'b0, w_pop};

    // Low target bits are forced to zero, so they are intentionally unread.
    assign w_unused = &{1'b0, redirect_pc[1:0]};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_FETCH;
            // Stop requesting once the push fills the queue.
            S_FETCH: if (w_push && (w_cnt_nxt == 2'd2)) w_state_nxt = S_WAIT;
            S_WAIT:  if (w_cnt_nxt != 2'd2) w_state_nxt = S_FETCH;
            // One idle cycle with rom_cs low aborts the ROM's in-flight access.
            S_REDIR: w_state_nxt = S_FETCH;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_flush) w_state_nxt = S_REDIR;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rom_cs = 1'b0;
        if (r_state == S_FETCH) rom_cs = 1'b1;
    end

    assign rom_addr = {2'b00, r_pc[31:2]};

    // ---------------- PC ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_pc <= RESET_PC;
        else if (w_flush) r_pc <= {redirect_pc[31:2], 2'b00};
        else if (w_push) r_pc <= r_pc + 32'd4;
    end

    // ---------------- fetch queue ----------------
    // Entry 0 is the head. On pop the tail shifts down; a push in the same
    // cycle lands behind whatever remains, so order is preserved.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= 2'd0;
            r_q_pc[0]   <= 32'd0;
            r_q_pc[1]   <= 32'd0;
            r_q_inst[0] <= 32'd0;
            r_q_inst[1] <= 32'd0;
        end else if (w_flush) begin
            r_cnt <= 2'd0;
        end else begin
            if (w_pop) begin
                r_q_pc[0]   <= r_q_pc[1];
                r_q_inst[0] <= r_q_inst[1];
            end
            if (w_push) begin
                r_q_pc[w_wr_slot[0]]   <= r_pc;
                r_q_inst[w_wr_slot[0]] <= rom_dout;
            end
            r_cnt <= w_cnt_nxt;
        end
    end

    assign if_valid = (r_cnt != 2'd0);
    assign if_inst  = if_valid ? r_q_inst[0] : 32'd0;
    assign if_pc    = if_valid ? r_q_pc[0]   : 32'd0;

    // ---------------- ROM wait counter ----------------
`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  r_perf_cnt <= 32'd0;
        else if (rom_cs && rom_stall) r_perf_cnt <= r_perf_cnt + 32'd1;
    end

    assign perf_stall_cnt = r_perf_cnt;
`else
    assign perf_stall_cnt = 32'h0;
`endif

endmodule
